// File: rtl/fifo_umbral_pkg.sv
// Shared constants for the fifo_umbral queue: default widths, depth and
// count-width derivation used by the top and the storage sub-module.
package fifo_umbral_pkg;

   localparam int DATA_WIDTH_DEF   = 6;
   localparam int ADDR_WIDTH_DEF   = 2;
   localparam int UMBRAL_WIDTH_DEF = 5;
   localparam int DEPTH_DEF        = 1 << ADDR_WIDTH_DEF;

   // Number of words addressable with aw address bits.
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction

   // Occupancy counter needs one extra bit to represent a completely full FIFO.
   function automatic int count_width(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// memoria_fifo: dual-port register file with synchronous write and a
// registered, asynchronously cleared read port. The read register is the
// FIFO's data_out, so it holds its value when no read is requested.
module memoria_fifo
   import fifo_umbral_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic [DATA_WIDTH-1:0] rd_data_d;

   // Storage write; contents are deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Next read-register value: new word on a read, otherwise hold.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Read register; a same-edge write to rd_addr is seen on the next read only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO for one switch queue with programmable
// almost-full / almost-empty thresholds and a sticky overflow/underflow flag.
// Optional macro FIFO_UMBRAL_ERR_CLR_EN adds an err_clr input that clears
// the sticky error without a full reset.
module fifo_umbral
   import fifo_umbral_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int UMBRAL_WIDTH = UMBRAL_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    valid_out,
   input  logic [UMBRAL_WIDTH-1:0] Umbral_alto,
   input  logic [UMBRAL_WIDTH-1:0] Umbral_bajo,
`ifdef FIFO_UMBRAL_ERR_CLR_EN
   input  logic                    err_clr,
`endif
   output logic                    fifo_empty,
   output logic                    fifo_full,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic                    fifo_error
);

   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   localparam int CNT_W = count_width(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;
   logic                  wr_en_s, rd_en_s, err_set_s, err_clr_s;

`ifdef FIFO_UMBRAL_ERR_CLR_EN
   assign err_clr_s = err_clr;
`else
   assign err_clr_s = 1'b0;
`endif

   // Occupancy flags decode straight from the count register.
   assign fifo_empty   = (count_q == CNT_W'(0));
   assign fifo_full    = (count_q == CNT_W'(DEPTH));
   assign almost_full  = (UMBRAL_WIDTH'(count_q) >= Umbral_alto);
   assign almost_empty = (UMBRAL_WIDTH'(count_q) <= Umbral_bajo);

   // Request arbitration, pointer/count update and sticky error next-state.
   always_comb begin
      // A pop on a full FIFO frees a slot, so a simultaneous push is accepted.
      rd_en_s   = pop && !fifo_empty;
      wr_en_s   = push && (!fifo_full || pop);
      err_set_s = (push && !pop && fifo_full) || (pop && fifo_empty);

      wr_ptr_d = wr_en_s ? (wr_ptr_q + ADDR_WIDTH'(1)) : wr_ptr_q;
      rd_ptr_d = rd_en_s ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;

      case ({wr_en_s, rd_en_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      valid_d = rd_en_s;

      // A new fault on the clear edge wins over the clear.
      if (err_set_s) begin
         error_d = 1'b1;
      end else if (err_clr_s) begin
         error_d = 1'b0;
      end else begin
         error_d = error_q;
      end
   end

   // Control state registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {ADDR_WIDTH{1'b0}};
         rd_ptr_q <= {ADDR_WIDTH{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
      end
   end

   assign valid_out  = valid_q;
   assign fifo_error = error_q;

   memoria_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_en_s),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral (depth 4, 6-bit data).
module tb_fifo_umbral;

   logic       clk;
   logic       reset;
   logic       push;
   logic [5:0] data_in;
   logic       pop;
   logic [5:0] data_out;
   logic       valid_out;
   logic [4:0] Umbral_alto;
   logic [4:0] Umbral_bajo;
`ifdef FIFO_UMBRAL_ERR_CLR_EN
   logic       err_clr;
`endif
   logic       fifo_empty;
   logic       fifo_full;
   logic       almost_full;
   logic       almost_empty;
   logic       fifo_error;

   int checks = 0;
   int errors = 0;

   fifo_umbral dut (
      .clk          (clk),
      .reset        (reset),
      .push         (push),
      .data_in      (data_in),
      .pop          (pop),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .Umbral_alto  (Umbral_alto),
      .Umbral_bajo  (Umbral_bajo),
`ifdef FIFO_UMBRAL_ERR_CLR_EN
      .err_clr      (err_clr),
`endif
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .fifo_error   (fifo_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given requests, then sample 1 time unit after the edge.
   task automatic cyc(input logic p, input logic q, input logic [5:0] d);
      push = p; pop = q; data_in = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; data_in = 6'h00;
   endtask

   initial begin
      reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 6'h00;
      Umbral_alto = 5'd3; Umbral_bajo = 5'd1;
`ifdef FIFO_UMBRAL_ERR_CLR_EN
      err_clr = 1'b0;
`endif
      // Reset state
      cyc(1'b0, 1'b0, 6'h00);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_full", fifo_full, 0);
      chk("rst_aempty", almost_empty, 1);
      chk("rst_afull", almost_full, 0);
      chk("rst_error", fifo_error, 0);
      chk("rst_dout", data_out, 0);
      chk("rst_valid", valid_out, 0);
      Umbral_alto = 5'd0; #1;
      chk("rst_afull_thr0", almost_full, 1);
      Umbral_alto = 5'd3; #1;
      reset = 1'b1;
      cyc(1'b0, 1'b0, 6'h00);
      chk("idle_empty", fifo_empty, 1);

      // Fill with thresholds alto=3 bajo=1
      cyc(1'b1, 1'b0, 6'h05);
      chk("p1_aempty", almost_empty, 1);
      chk("p1_empty", fifo_empty, 0);
      cyc(1'b1, 1'b0, 6'h0A);
      chk("p2_aempty", almost_empty, 0);
      chk("p2_afull", almost_full, 0);
      cyc(1'b1, 1'b0, 6'h0F);
      chk("p3_afull", almost_full, 1);
      chk("p3_full", fifo_full, 0);
      cyc(1'b1, 1'b0, 6'h11);
      chk("p4_full", fifo_full, 1);

      // Drain in order
      cyc(1'b0, 1'b1, 6'h00);
      chk("r1_data", data_out, 6'h05); chk("r1_valid", valid_out, 1);
      chk("r1_full", fifo_full, 0);
      cyc(1'b0, 1'b1, 6'h00);
      chk("r2_data", data_out, 6'h0A); chk("r2_valid", valid_out, 1);
      cyc(1'b0, 1'b1, 6'h00);
      chk("r3_data", data_out, 6'h0F);
      cyc(1'b0, 1'b1, 6'h00);
      chk("r4_data", data_out, 6'h11); chk("r4_empty", fifo_empty, 1);
      cyc(1'b0, 1'b0, 6'h00);
      chk("idle_valid", valid_out, 0); chk("idle_hold", data_out, 6'h11);
      chk("no_err_yet", fifo_error, 0);

      // Overflow: 0x22 dropped
      cyc(1'b1, 1'b0, 6'h01); cyc(1'b1, 1'b0, 6'h02);
      cyc(1'b1, 1'b0, 6'h03); cyc(1'b1, 1'b0, 6'h04);
      chk("ovf_pre_err", fifo_error, 0);
      cyc(1'b1, 1'b0, 6'h22);
      chk("ovf_err", fifo_error, 1); chk("ovf_full", fifo_full, 1);
      cyc(1'b0, 1'b1, 6'h00); chk("ovf_r1", data_out, 6'h01);
      cyc(1'b0, 1'b1, 6'h00); chk("ovf_r2", data_out, 6'h02);
      cyc(1'b0, 1'b1, 6'h00); chk("ovf_r3", data_out, 6'h03);
      cyc(1'b0, 1'b1, 6'h00); chk("ovf_r4", data_out, 6'h04);
      chk("ovf_empty", fifo_empty, 1);

      // Asynchronous reset mid-stream with two words held
      cyc(1'b1, 1'b0, 6'h2A); cyc(1'b1, 1'b0, 6'h2B);
      chk("mid_aempty_pre", almost_empty, 0);
      reset = 1'b0; #1;
      chk("mid_empty", fifo_empty, 1);
      chk("mid_aempty", almost_empty, 1);
      chk("mid_error", fifo_error, 0);
      chk("mid_dout", data_out, 0);
      reset = 1'b1;

      // Underflow, then push+pop on empty
      cyc(1'b1, 1'b0, 6'h15);
      chk("afterrst_empty", fifo_empty, 0);
      cyc(1'b0, 1'b1, 6'h00);
      chk("u_r_data", data_out, 6'h15);
      cyc(1'b0, 1'b1, 6'h00);
      chk("udf_err", fifo_error, 1); chk("udf_valid", valid_out, 0);
      chk("udf_hold", data_out, 6'h15); chk("udf_empty", fifo_empty, 1);
      cyc(1'b1, 1'b1, 6'h07);
      chk("pp_empty", fifo_empty, 0); chk("pp_valid", valid_out, 0);
      chk("pp_err", fifo_error, 1); chk("pp_hold", data_out, 6'h15);
      cyc(1'b0, 1'b1, 6'h00);
      chk("pp_read", data_out, 6'h07); chk("pp_read_valid", valid_out, 1);
      chk("pp_read_empty", fifo_empty, 1);

      // Reset pulse between edges clears the sticky error
      reset = 1'b0; #1;
      chk("pulse_err", fifo_error, 0);
      reset = 1'b1;

      // Full push+pop and threshold changes
      cyc(1'b1, 1'b0, 6'h41); cyc(1'b1, 1'b0, 6'h42);
      cyc(1'b1, 1'b0, 6'h43); cyc(1'b1, 1'b0, 6'h44);
      Umbral_alto = 5'd7; Umbral_bajo = 5'd5; #1;
      chk("thr_hi_afull", almost_full, 0);
      chk("thr_hi_aempty", almost_empty, 1);
      Umbral_alto = 5'd4; Umbral_bajo = 5'd3; #1;
      chk("thr_eq_afull", almost_full, 1);
      chk("thr_eq_aempty", almost_empty, 0);
      Umbral_alto = 5'd3; Umbral_bajo = 5'd1;
      cyc(1'b1, 1'b1, 6'h33);
      chk("fpp_valid", valid_out, 1); chk("fpp_data", data_out, 6'h41);
      chk("fpp_full", fifo_full, 1); chk("fpp_err", fifo_error, 0);
      cyc(1'b0, 1'b1, 6'h00); chk("fpp_r1", data_out, 6'h42);
      cyc(1'b0, 1'b1, 6'h00); chk("fpp_r2", data_out, 6'h43);
      cyc(1'b0, 1'b1, 6'h00); chk("fpp_r3", data_out, 6'h44);
      cyc(1'b0, 1'b1, 6'h00); chk("fpp_r4", data_out, 6'h33);
      chk("fpp_empty", fifo_empty, 1);

      // Pointer wrap: 6 pushes, 6 pops
      cyc(1'b1, 1'b0, 6'h30); cyc(1'b1, 1'b0, 6'h31); cyc(1'b1, 1'b0, 6'h32);
      cyc(1'b1, 1'b1, 6'h35); chk("wr_d0", data_out, 6'h30);
      cyc(1'b1, 1'b1, 6'h36); chk("wr_d1", data_out, 6'h31);
      cyc(1'b1, 1'b1, 6'h37); chk("wr_d2", data_out, 6'h32);
      chk("wr_mid_count3", almost_full, 1);
      cyc(1'b0, 1'b1, 6'h00); chk("wr_d3", data_out, 6'h35);
      cyc(1'b0, 1'b1, 6'h00); chk("wr_d4", data_out, 6'h36);
      cyc(1'b0, 1'b1, 6'h00); chk("wr_d5", data_out, 6'h37);
      chk("wr_empty", fifo_empty, 1); chk("wr_err", fifo_error, 0);

`ifdef FIFO_UMBRAL_ERR_CLR_EN
      // Error clear and set-wins behaviour
      cyc(1'b1, 1'b0, 6'h20); cyc(1'b1, 1'b0, 6'h21);
      cyc(1'b1, 1'b0, 6'h22); cyc(1'b1, 1'b0, 6'h23);
      cyc(1'b1, 1'b0, 6'h24);
      chk("clr_ovf", fifo_error, 1);
      err_clr = 1'b1;
      cyc(1'b0, 1'b0, 6'h00);
      chk("clr_done", fifo_error, 0);
      cyc(1'b1, 1'b0, 6'h25);
      chk("clr_setwins", fifo_error, 1);
      err_clr = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
